axistream_unpack_keep: RTL
==========================

Name: axistream_unpack_keep

Overview:
- Downstream counterpart to the packing stage: accepts one wide AXI-Stream word of NUM_PACK elements per beat and emits the elements one at a time on a narrow AXI-Stream.
- A per-element keep mask lets the final word of a packet be partially filled, so packets need not be multiples of NUM_PACK.
- Element order is selectable, so it matches the upstream packer's BIG_ENDIAN setting.
- Sits between the wide datapath and narrow byte/word consumers.

Parameters:
- DATA_WIDTH, 8, width of one output element in bits.
- NUM_PACK, 4, elements per input word; must be >= 2.
- BIG_ENDIAN, 1'b0, 0: slice 0 (bits DATA_WIDTH-1:0) is sent first; 1: slice NUM_PACK-1 is sent first.

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- src_tvalid  input  1  wide word valid
- src_tready  output  1  wide word accepted when src_tvalid && src_tready
- src_tdata  input  DATA_WIDTH*NUM_PACK  packed elements; slice i = bits [(i+1)*DATA_WIDTH-1 : i*DATA_WIDTH]
- src_tkeep  input  NUM_PACK  bit i qualifies slice i
- src_tlast  input  1  last wide word of packet
- dest_tvalid  output  1  element valid
- dest_tready  input  1  consumer ready
- dest_tdata  output  DATA_WIDTH  current element
- dest_tlast  output  1  high on the last kept element of a tlast word
- keep_err  output  1  registered flag, updated on every accepted src beat

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: dest_tvalid=0, keep_err=0, and the buffer is empty. While rst is high, src_tready=0 and dest_tvalid=0.
- Storage:
  - One wide holding register: data_buf, keep count k_buf, last_buf.
  - An element index idx, width $clog2(NUM_PACK).
  - A full flag.
- Keep decoding:
  - A keep mask is valid when it is nonzero and the kept slices form a contiguous prefix in send order.
    - LE: bits 0..k-1 set, all others clear.
    - BE: bits NUM_PACK-1 down to NUM_PACK-k set, all others clear.
  - k is the number of set bits (1..NUM_PACK).
- Load:
  - On an accepted src beat with a valid mask: data_buf<=src_tdata, k_buf<=k, last_buf<=src_tlast, idx<=0, full<=1, keep_err<=0.
  - On an accepted src beat with an invalid mask, the word is accepted and dropped: full is unchanged by the load, keep_err<=1. A tlast on a dropped word is lost; keep_err is the only indication.
- Output:
  - dest_tvalid = full && !rst.
  - dest_tdata = slice idx (LE) or slice NUM_PACK-1-idx (BE).
  - dest_tlast = last_buf && (idx == k_buf-1).
- Element handshake: when dest_tvalid && dest_tready:
  - If idx < k_buf-1: idx<=idx+1.
  - Otherwise the word is finished: full<=0, unless a new src beat is accepted in the same cycle, in which case the load takes priority.
- src_tready = !rst && (!full || (dest_tready && idx == k_buf-1)). Back-to-back words therefore stream with no bubble.
- Latency: an element of a word accepted in cycle N is first presented in cycle N+1.
- Throughput: one element per cycle while dest_tready=1. A word with k kept elements occupies k output cycles.
- Backpressure:
  - When dest_tready=0, dest_tdata, dest_tlast and idx hold stable.
  - dest_tvalid never drops without a handshake, except on rst.
- Reset mid-word: the buffered remainder is discarded, full<=0, idx<=0, keep_err<=0.
- keep_err semantics: it holds its value until the next accepted src beat.

Test Plan:
- LE, NUM_PACK=4, DATA_WIDTH=8; src word 0x44332211, keep=4'hF, tlast=1, dest_tready=1.
  - Required: dest 11,22,33,44 on consecutive cycles starting one cycle after acceptance.
  - Required: dest_tlast only on 44; keep_err=0.
- Back-to-back words 0xDDCCBBAA and 0x44332211, both keep=F, with src_tvalid held high.
  - Required: 8 consecutive dest beats AA..DD,11..44 with no gap.
  - Required: src_tready pulses in the cycle DD is accepted.
- BE=1; word 0x44332211, keep=4'hC, tlast=1.
  - Required: dest 44 then 33 (tlast on 33); next src accepted in the 33 handshake cycle.
- Partial LE word 0x00003322, keep=4'h3, tlast=1, with dest_tready toggling 1,0,0,1.
  - Required: 22, then 33 held stable for two stall cycles, then tlast on 33.
- Invalid keep: LE keep=4'h5 or keep=0.
  - Required: word accepted, no dest beats, keep_err=1 the next cycle.
  - Required: a following valid word clears keep_err.
- Assert rst while idx=2 of a 4-element word.
  - Required: next cycle dest_tvalid=0, src_tready=0 while rst is high.
  - Required: after release, a new word outputs from its first element.

Source files
------------

// File: rtl/axistream_unpack_keep_if.sv
// Wide-to-narrow AXI-Stream bundle for the unpacker: one wide keep-qualified
// source word per beat on the src side, one element per beat on the dest side.
interface axistream_unpack_keep_if #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_PACK   = 4
);
  // Handshake: a beat transfers on a rising clk edge where tvalid && tready.
  // A source holding tvalid keeps its payload stable until that edge and
  // never waits on tready before raising tvalid.
  logic                           src_tvalid;
  logic                           src_tready;
  logic [DATA_WIDTH*NUM_PACK-1:0] src_tdata;
  logic [NUM_PACK-1:0]            src_tkeep;
  logic                           src_tlast;

  logic                           dest_tvalid;
  logic                           dest_tready;
  logic [DATA_WIDTH-1:0]          dest_tdata;
  logic                           dest_tlast;

  modport master (
    output src_tvalid, src_tdata, src_tkeep, src_tlast, dest_tready,
    input  src_tready, dest_tvalid, dest_tdata, dest_tlast
  );

  modport slave (
    input  src_tvalid, src_tdata, src_tkeep, src_tlast, dest_tready,
    output src_tready, dest_tvalid, dest_tdata, dest_tlast
  );
endinterface

// File: rtl/axistream_unpack_keep.sv
// Splits one wide keep-qualified AXI-Stream word into NUM_PACK narrow elements,
// emitting only the kept prefix in the selected element order.
module axistream_unpack_keep #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_PACK   = 4,
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  axistream_unpack_keep_if.slave axis,
  output logic                  keep_err
);

  localparam int IW = (NUM_PACK > 1) ? $clog2(NUM_PACK) : 1;
  localparam int CW = $clog2(NUM_PACK + 1);

  logic [DATA_WIDTH*NUM_PACK-1:0] data_buf;
  logic [CW-1:0]                  k_buf;
  logic                           last_buf;
  logic [IW-1:0]                  idx;
  logic                           full;

  logic [CW-1:0]       k_in;
  logic [NUM_PACK-1:0] mask_exp;
  logic                keep_ok;
  logic                at_last;
  logic [IW-1:0]       sel;
  logic [DATA_WIDTH-1:0] slice;
  logic                src_fire;
  logic                dest_fire;

  // A mask is accepted only when it equals the contiguous prefix of its own
  // popcount, taken in send order.
  always_comb begin
    k_in     = '0;
    mask_exp = '0;
    for (int i = 0; i < NUM_PACK; i++) begin
      k_in = k_in + CW'(axis.src_tkeep[i]);
    end
    for (int i = 0; i < NUM_PACK; i++) begin
      if (BIG_ENDIAN) mask_exp[i] = (CW'(NUM_PACK - 1 - i) < k_in);
      else            mask_exp[i] = (CW'(i) < k_in);
    end
    keep_ok = (k_in != '0) && (axis.src_tkeep == mask_exp);
  end

  assign at_last = (CW'(idx) == (k_buf - CW'(1)));
  assign sel     = BIG_ENDIAN ? (IW'(NUM_PACK - 1) - idx) : idx;

  always_comb begin
    slice = '0;
    for (int i = 0; i < NUM_PACK; i++) begin
      if (IW'(i) == sel) slice = data_buf[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign axis.dest_tvalid = full && !rst;
  assign axis.dest_tdata  = slice;
  assign axis.dest_tlast  = last_buf && at_last;
  // Ready while the last element leaves lets back-to-back words stream bubble-free.
  assign axis.src_tready  = !rst && (!full || (axis.dest_tready && at_last));

  assign src_fire  = axis.src_tvalid && axis.src_tready;
  assign dest_fire = axis.dest_tvalid && axis.dest_tready;

  always_ff @(posedge clk) begin
    if (rst) begin
      data_buf <= '0;
      k_buf    <= '0;
      last_buf <= 1'b0;
      idx      <= '0;
      full     <= 1'b0;
      keep_err <= 1'b0;
    end else begin
      if (dest_fire) begin
        if (!at_last) idx  <= idx + IW'(1);
        else          full <= 1'b0;
      end
      // A dropped (bad-mask) word leaves the buffer state alone.
      if (src_fire) begin
        keep_err <= !keep_ok;
        if (keep_ok) begin
          data_buf <= axis.src_tdata;
          k_buf    <= k_in;
          last_buf <= axis.src_tlast;
          idx      <= '0;
          full     <= 1'b1;
        end
      end
    end
  end

endmodule
